regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Owns the single write port of the 32x32 register file (write enable, 5-bit destination, 32-bit data).
- Shares that port between two writeback requesters: the single-cycle ALU path and the long-latency load/memory path.
- Keeps a busy-register scoreboard for outstanding loads and drives a read-hazard stall for the decode stage.
- Sits between the execute/memory stages and the register file.

Parameters:
- XLEN, 32, data width of the register file.
- MAX_WAIT, 4, number of consecutive cycles the ALU may be denied before it is forced to win arbitration (minimum 1).

Ports:
- clk  input  1  system clock, all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- alu_valid_i  input  1  ALU writeback request.
- alu_rd_i  input  5  ALU destination register.
- alu_data_i  input  XLEN  ALU result.
- alu_ready_o  output  1  ALU request accepted this cycle when high together with alu_valid_i.
- mem_valid_i  input  1  load completion request.
- mem_rd_i  input  5  load destination register.
- mem_data_i  input  XLEN  load data.
- mem_ready_o  output  1  load request accepted this cycle when high together with mem_valid_i.
- issue_valid_i  input  1  a load is being issued this cycle.
- issue_rd_i  input  5  destination of the issued load; marked busy.
- rs1_addr_i  input  5  decode source register 1.
- rs2_addr_i  input  5  decode source register 2.
- hazard_o  output  1  stall request: a decode source register is busy.
- wr_en_o  output  1  register-file write enable.
- wr_addr_o  output  5  register-file destination register.
- wr_data_o  output  XLEN  register-file write data.

Behaviour:
- Reset (async assert, sync deassert on the next rising edge of clk):
  - wr_en_o=0, wr_addr_o=0, wr_data_o=0.
  - Busy vector all 0, starvation counter 0, hazard_o=0.
- Handshake: valid/ready. A transfer happens when valid and ready are both high. Requesters hold their valid, rd and data stable until the transfer.
- Arbitration (combinational ready):
  - Default priority is mem over ALU. mem_ready_o=1 and alu_ready_o=!mem_valid_i.
  - Exception: when starve_q==MAX_WAIT and alu_valid_i=1, the ALU wins. alu_ready_o=1 and mem_ready_o=0.
  - With no contention, each requester sees ready=1.
- Starvation counter:
  - Increments when alu_valid_i=1 and the ALU is not accepted, saturating at MAX_WAIT.
  - Clears on any ALU transfer.
  - Otherwise holds.
- Output stage (registered, one-cycle latency):
  - On a transfer, the next cycle shows wr_en_o=1 with the winner's rd and data. The source is recorded internally as src_q.
  - With no transfer, the next cycle shows wr_en_o=0; wr_addr_o and wr_data_o hold their last values.
  - A transfer to rd=0 is accepted but produces wr_en_o=0 (x0 is never written).
- Scoreboard (32-bit busy vector; bit 0 is hardwired 0):
  - Set: issue_valid_i with issue_rd_i≠0 sets busy[issue_rd_i].
  - Clear: on the rising edge where wr_en_o=1 and src_q=MEM, busy[wr_addr_o] is cleared. This is the same edge on which the register file writes.
  - Set and clear of the same register on the same edge: set wins.
  - Issue to a register that is already busy: the bit stays set.
- Hazard (combinational): hazard_o = (rs1_addr_i≠0 && busy[rs1_addr_i]) || (rs2_addr_i≠0 && busy[rs2_addr_i]).
  - hazard_o stays high during the cycle wr_en_o is writing the load result.
  - It drops the following cycle, when the register-file read returns the new value.
- ALU writes never touch the scoreboard.
- Reset mid-operation: a pending output write is discarded (wr_en_o=0 immediately), all busy bits clear and the counter clears. Requesters must re-present after reset.

Decomposition:
- Shared package, cpu_pkg:
  - REG_ADDR_W=5, XLEN=32, REG_COUNT=32.
  - Writeback source typedef wb_src_t {WB_SRC_ALU, WB_SRC_MEM}.
- One sub-module, regfile_scoreboard: the busy vector, the set/clear/priority rules and the hazard compare.
- Arbitration, the starvation counter and the output stage stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with all valids high. Required: wr_en_o=0, alu_ready_o and mem_ready_o are don't-care, busy=0, hazard_o=0.
- Single ALU write: alu_valid_i=1, rd=5, data=0xDEADBEEF for 1 cycle. Required: next cycle wr_en_o=1, wr_addr_o=5, wr_data_o=0xDEADBEEF; the cycle after, wr_en_o=0.
- Contention: alu_valid_i and mem_valid_i both held high, alu rd=3, mem rd=4, new mem data each cycle, MAX_WAIT=4.
  - Mem transfers for 4 cycles, alu_ready_o=0.
  - 5th cycle: alu_ready_o=1, mem_ready_o=0, then wr_addr_o=3.
- Load hazard:
  - Issue rd=7 with rs1_addr_i=7. Required: hazard_o=1 from the next cycle.
  - mem write rd=7, data=0x1234. Required: hazard_o stays 1 through the wr_en_o cycle and falls the cycle after.
- x0 handling: issue_rd_i=0, rs1_addr_i=0, then mem write rd=0. Required: hazard_o=0 throughout, wr_en_o=0, mem_ready_o=1.
- Same-edge set/clear: the mem write committing rd=9 coincides with issue_valid_i rd=9. Required: busy[9] remains 1 and hazard_o=1 with rs2_addr_i=9.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register-file geometry and writeback source encoding.
package cpu_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;
   localparam int REG_COUNT  = 32;

   typedef enum logic {
      WB_SRC_ALU = 1'b0,
      WB_SRC_MEM = 1'b1
   } wb_src_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-register scoreboard for outstanding loads and the decode read-hazard compare.
module regfile_scoreboard
   import cpu_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  set_en,
   input  logic [REG_ADDR_W-1:0] set_addr,
   input  logic                  clr_en,
   input  logic [REG_ADDR_W-1:0] clr_addr,
   input  logic [REG_ADDR_W-1:0] rs1_addr,
   input  logic [REG_ADDR_W-1:0] rs2_addr,
   output logic                  hazard
);

   logic [REG_COUNT-1:0] busy_q;
   logic [REG_COUNT-1:0] set_mask;
   logic [REG_COUNT-1:0] clr_mask;
   logic [REG_COUNT-1:0] busy_d;

   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (set_en && (set_addr != '0))
         set_mask[set_addr] = 1'b1;
      if (clr_en)
         clr_mask[clr_addr] = 1'b1;
      // Set is applied after clear so a re-issue on the commit edge keeps the bit.
      busy_d    = (busy_q & ~clr_mask) | set_mask;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy_q <= '0;
      else
         busy_q <= busy_d;
   end

   always_comb begin
      hazard = ((rs1_addr != '0) && busy_q[rs1_addr]) ||
               ((rs2_addr != '0) && busy_q[rs2_addr]);
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between ALU and load writeback,
// with ALU starvation protection and a load scoreboard driving the decode stall.
module regfile_wb_arbiter
   import cpu_pkg::*;
#(
   parameter int XLEN     = cpu_pkg::XLEN,
   parameter int MAX_WAIT = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  alu_valid_i,
   input  logic [REG_ADDR_W-1:0] alu_rd_i,
   input  logic [XLEN-1:0]       alu_data_i,
   output logic                  alu_ready_o,
   input  logic                  mem_valid_i,
   input  logic [REG_ADDR_W-1:0] mem_rd_i,
   input  logic [XLEN-1:0]       mem_data_i,
   output logic                  mem_ready_o,
   input  logic                  issue_valid_i,
   input  logic [REG_ADDR_W-1:0] issue_rd_i,
   input  logic [REG_ADDR_W-1:0] rs1_addr_i,
   input  logic [REG_ADDR_W-1:0] rs2_addr_i,
   output logic                  hazard_o,
   output logic                  wr_en_o,
   output logic [REG_ADDR_W-1:0] wr_addr_o,
   output logic [XLEN-1:0]       wr_data_o
);

   localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

   logic [CNT_W-1:0] starve_q;
   wb_src_t          src_q;
   logic             alu_force;
   logic             alu_xfer;
   logic             mem_xfer;

   // Arbitration: mem normally wins; a starved ALU request takes the port.
   always_comb begin
      alu_force   = alu_valid_i && (starve_q == MAX_WAIT_C);
      mem_ready_o = !alu_force;
      alu_ready_o = alu_force || !mem_valid_i;
      alu_xfer    = alu_valid_i && alu_ready_o;
      mem_xfer    = mem_valid_i && mem_ready_o;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         starve_q <= '0;
      else if (alu_xfer)
         starve_q <= '0;
      else if (alu_valid_i && (starve_q != MAX_WAIT_C))
         starve_q <= starve_q + 1'b1;
   end

   // Output stage: one-cycle registered write; x0 transfers are swallowed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en_o   <= 1'b0;
         wr_addr_o <= '0;
         wr_data_o <= '0;
         src_q     <= WB_SRC_ALU;
      end else if (alu_xfer) begin
         wr_en_o   <= (alu_rd_i != '0);
         wr_addr_o <= alu_rd_i;
         wr_data_o <= alu_data_i;
         src_q     <= WB_SRC_ALU;
      end else if (mem_xfer) begin
         wr_en_o   <= (mem_rd_i != '0);
         wr_addr_o <= mem_rd_i;
         wr_data_o <= mem_data_i;
         src_q     <= WB_SRC_MEM;
      end else begin
         wr_en_o   <= 1'b0;
      end
   end

   regfile_scoreboard u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .set_en   (issue_valid_i),
      .set_addr (issue_rd_i),
      .clr_en   (wr_en_o && (src_q == WB_SRC_MEM)),
      .clr_addr (wr_addr_o),
      .rs1_addr (rs1_addr_i),
      .rs2_addr (rs2_addr_i),
      .hazard   (hazard_o)
   );

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, arbitration, starvation, scoreboard.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        alu_valid_i;
   logic [4:0]  alu_rd_i;
   logic [31:0] alu_data_i;
   logic        alu_ready_o;
   logic        mem_valid_i;
   logic [4:0]  mem_rd_i;
   logic [31:0] mem_data_i;
   logic        mem_ready_o;
   logic        issue_valid_i;
   logic [4:0]  issue_rd_i;
   logic [4:0]  rs1_addr_i;
   logic [4:0]  rs2_addr_i;
   logic        hazard_o;
   logic        wr_en_o;
   logic [4:0]  wr_addr_o;
   logic [31:0] wr_data_o;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.XLEN(32), .MAX_WAIT(4)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid_i   (alu_valid_i),
      .alu_rd_i      (alu_rd_i),
      .alu_data_i    (alu_data_i),
      .alu_ready_o   (alu_ready_o),
      .mem_valid_i   (mem_valid_i),
      .mem_rd_i      (mem_rd_i),
      .mem_data_i    (mem_data_i),
      .mem_ready_o   (mem_ready_o),
      .issue_valid_i (issue_valid_i),
      .issue_rd_i    (issue_rd_i),
      .rs1_addr_i    (rs1_addr_i),
      .rs2_addr_i    (rs2_addr_i),
      .hazard_o      (hazard_o),
      .wr_en_o       (wr_en_o),
      .wr_addr_o     (wr_addr_o),
      .wr_data_o     (wr_data_o)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      alu_valid_i   = 1'b0;
      alu_rd_i      = '0;
      alu_data_i    = '0;
      mem_valid_i   = 1'b0;
      mem_rd_i      = '0;
      mem_data_i    = '0;
      issue_valid_i = 1'b0;
      issue_rd_i    = '0;
      rs1_addr_i    = '0;
      rs2_addr_i    = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b0;
      tick();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      alu_valid_i   = 1'b1;  alu_rd_i   = 5'd5;  alu_data_i = 32'hAAAA_0001;
      mem_valid_i   = 1'b1;  mem_rd_i   = 5'd6;  mem_data_i = 32'hBBBB_0002;
      issue_valid_i = 1'b1;  issue_rd_i = 5'd7;
      rs1_addr_i    = 5'd7;  rs2_addr_i = 5'd6;
      repeat (3) tick();
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b want 0", wr_en_o); end
      checks++; if (wr_addr_o !== 5'd0) begin errors++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr_o); end
      checks++; if (wr_data_o !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", wr_data_o); end
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL reset_hazard got %b want 0", hazard_o); end
      checks++; if (dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL reset_busy got %h want 0", dut.u_sb.busy_q); end
      idle_inputs();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL post_reset_wr_en got %b want 0", wr_en_o); end
   endtask

   task automatic test_single_alu();
      alu_valid_i = 1'b1; alu_rd_i = 5'd5; alu_data_i = 32'hDEAD_BEEF;
      #1;
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL alu_ready got %b want 1", alu_ready_o); end
      tick();
      alu_valid_i = 1'b0;
      checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL alu_wr_en got %b want 1", wr_en_o); end
      checks++; if (wr_addr_o !== 5'd5) begin errors++; $display("FAIL alu_wr_addr got %0d want 5", wr_addr_o); end
      checks++; if (wr_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_wr_data got %h want deadbeef", wr_data_o); end
      tick();
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL alu_wr_en_drop got %b want 0", wr_en_o); end
      checks++; if (wr_addr_o !== 5'd5) begin errors++; $display("FAIL alu_addr_hold got %0d want 5", wr_addr_o); end
      checks++; if (wr_data_o !== 32'hDEAD_BEEF) begin errors++; $display("FAIL alu_data_hold got %h want deadbeef", wr_data_o); end
   endtask

   task automatic test_contention();
      alu_valid_i = 1'b1; alu_rd_i = 5'd3; alu_data_i = 32'hA1A1_0003;
      mem_valid_i = 1'b1; mem_rd_i = 5'd4; mem_data_i = 32'h1000_0000;
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL cont_alu_ready[%0d] got %b want 0", i, alu_ready_o); end
         checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL cont_mem_ready[%0d] got %b want 1", i, mem_ready_o); end
         tick();
         checks++; if ((wr_en_o !== 1'b1) || (wr_addr_o !== 5'd4) || (wr_data_o !== (32'h1000_0000 + i)))
            begin errors++; $display("FAIL cont_mem_write[%0d] got en=%b addr=%0d data=%h want en=1 addr=4 data=%h",
                                     i, wr_en_o, wr_addr_o, wr_data_o, 32'h1000_0000 + i); end
         mem_data_i = 32'h1000_0001 + i;
      end
      #1;
      checks++; if (alu_ready_o !== 1'b1) begin errors++; $display("FAIL starve_alu_ready got %b want 1", alu_ready_o); end
      checks++; if (mem_ready_o !== 1'b0) begin errors++; $display("FAIL starve_mem_ready got %b want 0", mem_ready_o); end
      tick();
      alu_valid_i = 1'b0;
      checks++; if ((wr_en_o !== 1'b1) || (wr_addr_o !== 5'd3) || (wr_data_o !== 32'hA1A1_0003))
         begin errors++; $display("FAIL starve_alu_write got en=%b addr=%0d data=%h want en=1 addr=3 data=a1a10003",
                                  wr_en_o, wr_addr_o, wr_data_o); end
      // Counter cleared on the ALU win: a new ALU request loses to mem again.
      alu_valid_i = 1'b1;
      #1;
      checks++; if (alu_ready_o !== 1'b0) begin errors++; $display("FAIL starve_cleared got alu_ready=%b want 0", alu_ready_o); end
      tick();
      checks++; if ((wr_addr_o !== 5'd4) || (wr_data_o !== 32'h1000_0004))
         begin errors++; $display("FAIL cont_mem_after got addr=%0d data=%h want addr=4 data=10000004", wr_addr_o, wr_data_o); end
      idle_inputs();
      tick();
   endtask

   task automatic test_load_hazard();
      issue_valid_i = 1'b1; issue_rd_i = 5'd7; rs1_addr_i = 5'd7;
      #1;
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL hz_before_issue got %b want 0", hazard_o); end
      tick();
      issue_valid_i = 1'b0;
      #1;
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL hz_after_issue got %b want 1", hazard_o); end
      mem_valid_i = 1'b1; mem_rd_i = 5'd7; mem_data_i = 32'h0000_1234;
      tick();
      mem_valid_i = 1'b0;
      #1;
      checks++; if ((wr_en_o !== 1'b1) || (wr_addr_o !== 5'd7) || (wr_data_o !== 32'h0000_1234))
         begin errors++; $display("FAIL hz_load_write got en=%b addr=%0d data=%h want en=1 addr=7 data=00001234",
                                  wr_en_o, wr_addr_o, wr_data_o); end
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL hz_during_write got %b want 1", hazard_o); end
      tick();
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL hz_after_write got %b want 0", hazard_o); end
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL hz_wr_en_drop got %b want 0", wr_en_o); end
      idle_inputs();
   endtask

   task automatic test_alu_no_clear();
      issue_valid_i = 1'b1; issue_rd_i = 5'd10; rs2_addr_i = 5'd10;
      tick();
      issue_valid_i = 1'b0;
      alu_valid_i = 1'b1; alu_rd_i = 5'd10; alu_data_i = 32'h0BAD_F00D;
      tick();
      alu_valid_i = 1'b0;
      tick();
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL alu_keeps_busy got hazard=%b want 1", hazard_o); end
      do_reset();
   endtask

   task automatic test_x0();
      issue_valid_i = 1'b1; issue_rd_i = 5'd0; rs1_addr_i = 5'd0;
      tick();
      issue_valid_i = 1'b0;
      #1;
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL x0_hazard_issue got %b want 0", hazard_o); end
      mem_valid_i = 1'b1; mem_rd_i = 5'd0; mem_data_i = 32'hFFFF_FFFF;
      #1;
      checks++; if (mem_ready_o !== 1'b1) begin errors++; $display("FAIL x0_mem_ready got %b want 1", mem_ready_o); end
      tick();
      mem_valid_i = 1'b0;
      #1;
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL x0_wr_en got %b want 0", wr_en_o); end
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL x0_hazard_write got %b want 0", hazard_o); end
      checks++; if (dut.u_sb.busy_q !== 32'd0) begin errors++; $display("FAIL x0_busy got %h want 0", dut.u_sb.busy_q); end
      idle_inputs();
   endtask

   task automatic test_same_edge();
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      tick();
      issue_valid_i = 1'b0;
      rs2_addr_i = 5'd9;
      mem_valid_i = 1'b1; mem_rd_i = 5'd9; mem_data_i = 32'h0000_0099;
      tick();
      mem_valid_i = 1'b0;
      checks++; if ((wr_en_o !== 1'b1) || (wr_addr_o !== 5'd9))
         begin errors++; $display("FAIL same_edge_write got en=%b addr=%0d want en=1 addr=9", wr_en_o, wr_addr_o); end
      issue_valid_i = 1'b1; issue_rd_i = 5'd9;
      #1;
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL same_edge_hz_commit got %b want 1", hazard_o); end
      tick();
      issue_valid_i = 1'b0;
      #1;
      checks++; if (dut.u_sb.busy_q[9] !== 1'b1) begin errors++; $display("FAIL same_edge_busy9 got %b want 1", dut.u_sb.busy_q[9]); end
      checks++; if (hazard_o !== 1'b1) begin errors++; $display("FAIL same_edge_hazard got %b want 1", hazard_o); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_op();
      issue_valid_i = 1'b1; issue_rd_i = 5'd12; rs1_addr_i = 5'd12;
      alu_valid_i = 1'b1; alu_rd_i = 5'd13; alu_data_i = 32'h1313_1313;
      tick();
      idle_inputs();
      rs1_addr_i = 5'd12;
      checks++; if (wr_en_o !== 1'b1) begin errors++; $display("FAIL mid_pending_wr_en got %b want 1", wr_en_o); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (wr_en_o !== 1'b0) begin errors++; $display("FAIL mid_reset_wr_en got %b want 0", wr_en_o); end
      checks++; if (hazard_o !== 1'b0) begin errors++; $display("FAIL mid_reset_hazard got %b want 0", hazard_o); end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
   endtask

   initial begin
      idle_inputs();
      rst_n = 1'b0;
      test_reset();
      test_single_alu();
      test_contention();
      test_load_hazard();
      test_alu_no_clear();
      test_x0();
      test_same_edge();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
